// File: rtl/mipi_dphy_pkg.sv
// Shared D-PHY definitions: escape-clock wait-timer FSM states and the timing
// constants, in TxClkEsc cycles, that the LP control FSMs load into wait timers.
package mipi_dphy_pkg;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_COUNT = 2'd1,
        T_DONE  = 2'd2
    } timer_state_t;

    localparam int T_LPX     = 2;
    localparam int T_prepare = 1;
    localparam int T_POST    = 2;
    localparam int T_TRAIL   = 2;
    localparam int T_Wakeup  = 20000;

endpackage

// File: rtl/lp_wait_timer.sv
// Escape-clock wait timer: one-cycle registered time_flag after max(time_wait,1) enabled edges.
// Latency N edges from the first enable edge; dropping enable aborts. LP_WAIT_TIMER_STATUS_EN adds timer_busy/elapsed.
module lp_wait_timer
    import mipi_dphy_pkg::*;
#(
    parameter int TIME_WAIT_WIDTH = 32
) (
    input  logic                       TxClkEsc,
    input  logic                       rst_n,
    input  logic                       timer_enable,
    input  logic [TIME_WAIT_WIDTH-1:0] time_wait,
`ifdef LP_WAIT_TIMER_STATUS_EN
    output logic                       timer_busy,
    output logic [TIME_WAIT_WIDTH-1:0] elapsed,
`endif
    output logic                       time_flag
);

    localparam logic [TIME_WAIT_WIDTH-1:0] ONE = TIME_WAIT_WIDTH'(1);

    timer_state_t               state;
    logic [TIME_WAIT_WIDTH-1:0] cnt;
    logic [TIME_WAIT_WIDTH-1:0] wait_q;
    logic [TIME_WAIT_WIDTH-1:0] n_eff;

    // A zero wait behaves as a single cycle.
    assign n_eff = (wait_q == '0) ? ONE : wait_q;

    always_ff @(posedge TxClkEsc or negedge rst_n) begin
        if (!rst_n) begin
            state     <= T_IDLE;
            cnt       <= '0;
            wait_q    <= '0;
            time_flag <= 1'b0;
        end else begin
            case (state)
                T_IDLE: begin
                    time_flag <= 1'b0;
                    if (timer_enable) begin
                        state     <= T_COUNT;
                        wait_q    <= time_wait;
                        cnt       <= ONE;
                        time_flag <= (time_wait <= ONE);
                    end
                end
                T_COUNT: begin
                    if (!timer_enable) begin
                        state     <= T_IDLE;
                        cnt       <= '0;
                        time_flag <= 1'b0;
                    end else if (cnt == n_eff) begin
                        // End of the flag cycle with enable still held: park until it drops.
                        state     <= T_DONE;
                        time_flag <= 1'b0;
                    end else begin
                        cnt       <= cnt + ONE;
                        time_flag <= (cnt == n_eff - ONE);
                    end
                end
                T_DONE: begin
                    time_flag <= 1'b0;
                    if (!timer_enable) begin
                        state <= T_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state     <= T_IDLE;
                    cnt       <= '0;
                    time_flag <= 1'b0;
                end
            endcase
        end
    end

`ifdef LP_WAIT_TIMER_STATUS_EN
    assign timer_busy = (state == T_COUNT);
    assign elapsed    = cnt;
`endif

endmodule

// File: tb/tb_lp_wait_timer.sv
// Scoreboard bench for lp_wait_timer: expected flag cycles are queued as stimulus is
// driven and popped by a monitor whenever time_flag is seen high.
module tb_lp_wait_timer;

    logic        TxClkEsc = 1'b0;
    logic        rst_n;
    logic        timer_enable;
    logic [31:0] time_wait;
    logic        time_flag;

    logic        en4;
    logic [3:0]  tw4;
    logic        flag4;

`ifdef LP_WAIT_TIMER_STATUS_EN
    logic        timer_busy;
    logic [31:0] elapsed;
    logic        busy4;
    logic [3:0]  elapsed4;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int q_exp[$];
    int q4[$];

    always #5 TxClkEsc = ~TxClkEsc;

    lp_wait_timer u_dut (
        .TxClkEsc     (TxClkEsc),
        .rst_n        (rst_n),
        .timer_enable (timer_enable),
        .time_wait    (time_wait),
`ifdef LP_WAIT_TIMER_STATUS_EN
        .timer_busy   (timer_busy),
        .elapsed      (elapsed),
`endif
        .time_flag    (time_flag)
    );

    lp_wait_timer #(.TIME_WAIT_WIDTH(4)) u_dut4 (
        .TxClkEsc     (TxClkEsc),
        .rst_n        (rst_n),
        .timer_enable (en4),
        .time_wait    (tw4),
`ifdef LP_WAIT_TIMER_STATUS_EN
        .timer_busy   (busy4),
        .elapsed      (elapsed4),
`endif
        .time_flag    (flag4)
    );

    // Flag monitors: every observed pulse must match the head of its queue.
    always @(posedge TxClkEsc) begin
        int exp;
        cyc++;
        #1;
        if (time_flag) begin
            checks++;
            if (q_exp.size() == 0) begin
                failures++;
                $display("FAIL flag_unexpected: flag seen at cycle %0d, required none", cyc);
            end else begin
                exp = q_exp.pop_front();
                if (cyc !== exp) begin
                    failures++;
                    $display("FAIL flag_cycle: flag at cycle %0d, required cycle %0d", cyc, exp);
                end
            end
        end
        if (flag4) begin
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL flag4_unexpected: flag seen at cycle %0d, required none", cyc);
            end else begin
                exp = q4.pop_front();
                if (cyc !== exp) begin
                    failures++;
                    $display("FAIL flag4_cycle: flag at cycle %0d, required cycle %0d", cyc, exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge TxClkEsc);
    endtask

    task automatic end_check(input string name);
        checks++;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL %s_missing: %0d flags still pending, required 0", name, q_exp.size());
        end
        q_exp.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; timer_enable = 1'b0; time_wait = '0; en4 = 1'b0; tw4 = '0;
        tick(2);
        checks++;
        if (time_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_flag: time_flag=%b, required 0", time_flag);
        end
`ifdef LP_WAIT_TIMER_STATUS_EN
        checks++;
        if (timer_busy !== 1'b0 || elapsed !== 32'd0) begin
            failures++;
            $display("FAIL reset_status: busy=%b elapsed=%0d, required 0/0", timer_busy, elapsed);
        end
`endif
        rst_n = 1'b1;
        tick(2);
        end_check("reset");
    endtask

    task automatic test_wait2_held;
        time_wait = 32'd2; timer_enable = 1'b1;
        q_exp.push_back(cyc + 2);
        tick(10);
        timer_enable = 1'b0;
        tick(2);
        end_check("wait2_held");
    endtask

    task automatic test_wait0_and_1;
        for (int v = 0; v < 2; v++) begin
            time_wait = v; timer_enable = 1'b1;
            q_exp.push_back(cyc + 1);
            tick(4);
            timer_enable = 1'b0;
            tick(2);
            end_check("wait_short");
        end
    endtask

    task automatic test_back_to_back;
        time_wait = 32'd2; timer_enable = 1'b1;
        q_exp.push_back(cyc + 2);
        tick(2);
        timer_enable = 1'b0;
        tick(1);
        time_wait = 32'd1; timer_enable = 1'b1;
        q_exp.push_back(cyc + 1);
        tick(3);
        timer_enable = 1'b0;
        tick(2);
        end_check("back_to_back");
    endtask

    task automatic test_abort_wakeup;
        time_wait = 32'd20000; timer_enable = 1'b1;
        tick(500);
        timer_enable = 1'b0;
        tick(3);
        end_check("abort");
        timer_enable = 1'b1;
        q_exp.push_back(cyc + 20000);
        tick(20003);
        timer_enable = 1'b0;
        tick(2);
        end_check("wakeup_full");
    endtask

    task automatic test_wait_change;
        time_wait = 32'd5; timer_enable = 1'b1;
        q_exp.push_back(cyc + 5);
        tick(2);
        time_wait = 32'd9;
        tick(10);
        timer_enable = 1'b0;
        tick(2);
        end_check("wait_change");
    endtask

    task automatic test_reset_mid_count;
        time_wait = 32'd4; timer_enable = 1'b1;
        tick(3);
        rst_n = 1'b0; timer_enable = 1'b0;
        tick(1);
        checks++;
        if (time_flag !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_flag: time_flag=%b, required 0", time_flag);
        end
        rst_n = 1'b1;
        tick(8);
        end_check("reset_mid");
        timer_enable = 1'b1; time_wait = 32'd3;
        q_exp.push_back(cyc + 3);
        tick(5);
        timer_enable = 1'b0;
        tick(2);
        end_check("after_reset_run");
    endtask

    task automatic test_max_wait;
        tw4 = 4'd15; en4 = 1'b1;
        q4.push_back(cyc + 15);
        tick(18);
        en4 = 1'b0;
        tick(2);
        checks++;
        if (q4.size() != 0) begin
            failures++;
            $display("FAIL max_wait_missing: %0d flags pending, required 0", q4.size());
        end
        q4.delete();
    endtask

`ifdef LP_WAIT_TIMER_STATUS_EN
    task automatic test_status;
        int exp_busy[7]    = '{1, 1, 1, 0, 0, 0, 0};
        int exp_elapsed[7] = '{1, 2, 3, 3, 3, 0, 0};
        time_wait = 32'd3; timer_enable = 1'b1;
        q_exp.push_back(cyc + 3);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            if (i == 4) timer_enable = 1'b0;
            checks++;
            if (timer_busy !== exp_busy[i][0] || elapsed !== 32'(exp_elapsed[i])) begin
                failures++;
                $display("FAIL status_%0d: busy=%b elapsed=%0d, required %0d/%0d",
                         i, timer_busy, elapsed, exp_busy[i], exp_elapsed[i]);
            end
        end
        end_check("status");
    endtask
`endif

    initial begin
        test_reset();
        test_wait2_held();
        test_wait0_and_1();
        test_back_to_back();
        test_abort_wakeup();
        test_wait_change();
        test_reset_mid_count();
        test_max_wait();
`ifdef LP_WAIT_TIMER_STATUS_EN
        test_status();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
